// File: rtl/vga_fb_reader_if.sv
// Frame-buffer memory read port plus the outgoing pixel-word stream.
// Stream handshake: a word moves on a cycle where pix_valid and pix_ready are both high; the producer holds pix_data/pix_sop/pix_eop steady while pix_valid is high and pix_ready is low.
interface vga_fb_reader_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [31:0]       mem_readdata;
    logic [31:0]       pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sop;
    logic              pix_eop;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  mem_readdata,
        output pix_data, pix_valid, pix_sop, pix_eop,
        input  pix_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output mem_readdata,
        input  pix_data, pix_valid, pix_sop, pix_eop,
        output pix_ready
    );
endinterface

// File: rtl/vga_fb_reader.sv
// Fetches a run of frame-buffer words from a 1-cycle-latency memory and streams them
// out through a small FIFO with sop/eop framing; supports abort and zero-length starts.
module vga_fb_reader #(
    parameter int ADDR_W     = 15,
    parameter int NUM_WORDS  = 25000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ADDR_W-1:0]             length,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    dbg_state_o,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_count_o,
    vga_fb_reader_if.master               bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic              first_q, first_d;
    logic              infl_q, infl_d;
    logic              infl_sop_q, infl_sop_d;
    logic              infl_eop_q, infl_eop_d;
    logic              done_zero_q, done_zero_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [33:0]       fifo_q [FIFO_DEPTH];

    logic        strobe, aborting, push, pop, eop_xfer;
    logic [33:0] head;

    // Counting the in-flight word as occupied means the FIFO can never be overrun.
    assign strobe   = (state_q == S_FETCH) && !abort && ((count_q + CNT_W'(infl_q)) < DEPTH_C);
    assign aborting = abort && (state_q != S_IDLE);
    assign push     = infl_q && !aborting;
    assign head     = fifo_q[rd_ptr_q];
    assign pop      = bus.pix_valid && bus.pix_ready;
    assign eop_xfer = pop && head[32] && (state_q == S_DRAIN);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        first_d     = first_q;
        infl_d      = strobe;
        infl_sop_d  = first_q;
        infl_eop_d  = (remain_q == ADDR_W'(1));
        done_zero_d = 1'b0;
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d  = S_FETCH;
                        addr_d   = base_addr;
                        remain_d = length;
                        first_d  = 1'b1;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                    end else begin
                        done_zero_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (strobe) begin
                    addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
                    remain_d = remain_q - ADDR_W'(1);
                    first_d  = 1'b0;
                    if (remain_q == ADDR_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (eop_xfer) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (aborting) begin
            state_d  = S_IDLE;
            infl_d   = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            first_q     <= 1'b0;
            infl_q      <= 1'b0;
            infl_sop_q  <= 1'b0;
            infl_eop_q  <= 1'b0;
            done_zero_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            first_q     <= first_d;
            infl_q      <= infl_d;
            infl_sop_q  <= infl_sop_d;
            infl_eop_q  <= infl_eop_d;
            done_zero_q <= done_zero_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {infl_sop_q, infl_eop_q, bus.mem_readdata};
        end
    end

    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = strobe;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;
    assign bus.pix_valid      = (count_q != '0);
    assign bus.pix_data       = head[31:0];
    assign bus.pix_sop        = bus.pix_valid && head[33];
    assign bus.pix_eop        = bus.pix_valid && head[32];

    assign busy             = (state_q != S_IDLE);
    assign done             = done_zero_q || (eop_xfer && !aborting);
    assign dbg_state_o      = state_q;
    assign dbg_fifo_count_o = count_q;
endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: directed scenarios plus randomized frames against a
// frame-level model (expected strobe addresses and sop/eop-tagged words).
module tb_vga_fb_reader;
    localparam int ADDR_W     = 15;
    localparam int NUM_WORDS  = 25000;
    localparam int FIFO_DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;
    logic [3:0]        dbg_cnt;

    vga_fb_reader_if #(.ADDR_W(ADDR_W)) bus ();

    vga_fb_reader #(
        .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .dbg_state_o(dbg_state), .dbg_fifo_count_o(dbg_cnt), .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    logic rand_ready = 1'b0;
    logic [15:0] salt = 16'h0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [33:0] exp_q[$];
    int strobe_cyc_q[$];

    function automatic logic [31:0] word_of(input logic [15:0] s, input logic [ADDR_W-1:0] a);
        return {s, 1'b0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory: word valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        bus.mem_readdata <= bus.mem_chipselect ? word_of(salt, bus.mem_address) : $urandom;
    end

    // Scoreboard: strobe addresses and delivered words against the frame model.
    always @(negedge clk) begin
        if (!reset && !abort) begin
            if (bus.mem_chipselect) begin
                strobe_cnt++;
                strobe_cyc_q.push_back(cyc);
                chk("strobe_expected", 64'(exp_addr_q.size() > 0), 1);
                if (exp_addr_q.size() > 0) chk("strobe_addr", 64'(bus.mem_address), 64'(exp_addr_q.pop_front()));
            end
            if (bus.pix_valid && bus.pix_ready) begin
                chk("word_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    chk("pix_word", 64'({bus.pix_sop, bus.pix_eop, bus.pix_data}), 64'(e));
                    if (e[32]) chk("done_with_eop", 64'(done), 1);
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.pix_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic launch(input int base, input int len);
        salt = 16'($urandom);
        for (int i = 0; i < len; i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'((base + i) % NUM_WORDS);
            exp_addr_q.push_back(a);
            exp_q.push_back({(i == 0), (i == len - 1), word_of(salt, a)});
        end
        base_addr = ADDR_W'(base);
        length    = ADDR_W'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_finished"}, 64'(n < budget), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_cs"}, 64'(bus.mem_chipselect), 0);
        chk({tag, "_valid"}, 64'(bus.pix_valid), 0);
        chk({tag, "_sop"}, 64'(bus.pix_sop), 0);
        chk({tag, "_eop"}, 64'(bus.pix_eop), 0);
        chk({tag, "_addr"}, 64'(bus.mem_address), 0);
        chk({tag, "_state"}, 64'(dbg_state), 0);
        chk({tag, "_count"}, 64'(dbg_cnt), 0);
    endtask

    initial begin
        int s0, d0, n;
        logic [33:0] held;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; length = '0; bus.pix_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        chk("mem_write", 64'(bus.mem_write), 0);
        chk("mem_byteenable", 64'(bus.mem_byteenable), 64'hF);
        chk("mem_clken", 64'(bus.mem_clken), 1);
        reset = 1'b0;
        tick();

        // Streaming
        bus.pix_ready = 1'b1;
        strobe_cyc_q.delete();
        s0 = strobe_cnt; d0 = done_cnt;
        launch(16, 4);
        wait_idle("stream", 50);
        chk("stream_strobes", 64'(strobe_cnt - s0), 4);
        chk("stream_strobe_cycles", 64'(strobe_cyc_q.size() == 4 ? strobe_cyc_q[3] - strobe_cyc_q[0] : -1), 3);
        chk("stream_done", 64'(done_cnt - d0), 1);
        chk("stream_busy_after", 64'(busy), 0);

        // Backpressure
        bus.pix_ready = 1'b0;
        s0 = strobe_cnt; d0 = done_cnt;
        launch(100, 20);
        repeat (30) tick();
        chk("bp_fifo_full", 64'(dbg_cnt), FIFO_DEPTH);
        chk("bp_strobes", 64'(strobe_cnt - s0), FIFO_DEPTH);
        chk("bp_valid", 64'(bus.pix_valid), 1);
        held = {bus.pix_sop, bus.pix_eop, bus.pix_data};
        repeat (3) tick();
        chk("bp_hold_stable", 64'({bus.pix_sop, bus.pix_eop, bus.pix_data}), 64'(held));
        bus.pix_ready = 1'b1;
        wait_idle("bp", 200);
        chk("bp_done", 64'(done_cnt - d0), 1);
        chk("bp_all_strobes", 64'(strobe_cnt - s0), 20);

        // Address wrap
        d0 = done_cnt;
        launch(24998, 4);
        wait_idle("wrap", 50);
        chk("wrap_done", 64'(done_cnt - d0), 1);

        // Zero length
        s0 = strobe_cnt; d0 = done_cnt;
        base_addr = 15'd7; length = '0; start = 1'b1;
        @(negedge clk);
        chk("zero_done_early", 64'(done), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_done_pulse", 64'(done), 1);
        chk("zero_busy", 64'(busy), 0);
        @(negedge clk);
        chk("zero_done_single", 64'(done), 0);
        tick();
        chk("zero_no_strobe", 64'(strobe_cnt - s0), 0);
        chk("zero_done_count", 64'(done_cnt - d0), 1);

        // Start while busy is ignored
        rand_ready = 1'b1;
        s0 = strobe_cnt; d0 = done_cnt;
        launch(200, 10);
        tick();
        base_addr = 15'd5; length = 15'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("ignored_start", 300);
        chk("ignored_start_done", 64'(done_cnt - d0), 1);
        chk("ignored_start_strobes", 64'(strobe_cnt - s0), 10);
        rand_ready = 1'b0;

        // Abort with a read in flight
        bus.pix_ready = 1'b0;
        s0 = strobe_cnt; d0 = done_cnt;
        launch(300, 20);
        n = 0;
        while (strobe_cnt - s0 < 3 && n < 50) begin
            tick();
            n++;
        end
        chk("abort_reach_strobes", 64'(n < 50), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", 64'(dbg_state), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_valid", 64'(bus.pix_valid), 0);
        chk("abort_done", 64'(done), 0);
        exp_addr_q.delete();
        exp_q.delete();
        repeat (4) tick();
        chk("abort_discard", 64'(dbg_cnt), 0);
        chk("abort_no_done", 64'(done_cnt - d0), 0);
        bus.pix_ready = 1'b1;
        launch(300, 6);
        wait_idle("post_abort", 60);
        chk("post_abort_done", 64'(done_cnt - d0), 1);

        // Randomized frames
        rand_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int b, l;
            b = ($urandom_range(0, 1) != 0) ? $urandom_range(NUM_WORDS - 20, NUM_WORDS - 1)
                                             : $urandom_range(0, NUM_WORDS - 1);
            l = $urandom_range(1, 30);
            d0 = done_cnt;
            launch(b, l);
            wait_idle("rand", 600);
            chk("rand_done", 64'(done_cnt - d0), 1);
        end
        rand_ready = 1'b0;

        // Asynchronous reset mid-frame
        bus.pix_ready = 1'b0;
        launch(1000, 15);
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        exp_addr_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.pix_ready = 1'b1;
        d0 = done_cnt;
        launch(1000, 5);
        wait_idle("post_reset", 60);
        chk("post_reset_done", 64'(done_cnt - d0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
